// File: rtl/aes_key_mem.sv
// AES round-key memory: expands an AES-128/256 cipher key into round keys, one
// round key per cycle, and serves them combinationally by round index.
module aes_key_mem #(
    parameter logic [3:0] AES128_ROUNDS = 4'ha,
    parameter logic [3:0] AES256_ROUNDS = 4'he
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         keylen,
    input  logic [255:0] key,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready
);

    // state | meaning
    // IDLE  | no key expanded since reset
    // GEN   | writing one round key per cycle at index gen_cnt
    // DONE  | all round keys valid, ready=1
    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    localparam int NKEYS = int'(AES256_ROUNDS) + 1;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t         state, state_nxt;
    logic [255:0]   key_reg;
    logic           keylen_reg;
    logic [3:0]     gen_cnt;
    logic [7:0]     rcon;
    logic [127:0]   mem [0:NKEYS-1];
    logic [3:0]     last_idx;
    logic           start, gen_we;
    logic [3:0]     idx1, idx2;
    logic [127:0]   prev1, prev2, base, new_key;
    logic [31:0]    t, n0, n1, n2, n3;
    logic           rcon_adv;

    assign last_idx = keylen_reg ? AES256_ROUNDS : AES128_ROUNDS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (init) state_nxt = GEN;
            GEN:     if (gen_cnt == last_idx) state_nxt = DONE;
            DONE:    if (init) state_nxt = GEN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready  = (state == DONE);
        start  = init && (state != GEN);
        gen_we = (state == GEN);
    end

    // Key i depends on key i-1 (AES-128) or keys i-2 and i-1 (AES-256).
    always_comb begin
        idx1     = (gen_cnt == 4'd0) ? 4'd0 : gen_cnt - 4'd1;
        idx2     = (gen_cnt < 4'd2)  ? 4'd0 : gen_cnt - 4'd2;
        prev1    = mem[idx1];
        prev2    = mem[idx2];
        base     = keylen_reg ? prev2 : prev1;
        rcon_adv = (gen_cnt != 4'd0) && (!keylen_reg || !gen_cnt[0]);
        if (!keylen_reg || !gen_cnt[0])
            t = sub_word({prev1[23:0], prev1[31:24]}) ^ {rcon, 24'h0};
        else
            t = sub_word(prev1[31:0]);
        n0 = base[127:96] ^ t;
        n1 = n0 ^ base[95:64];
        n2 = n1 ^ base[63:32];
        n3 = n2 ^ base[31:0];
        if (gen_cnt == 4'd0)
            new_key = key_reg[255:128];
        else if (keylen_reg && gen_cnt == 4'd1)
            new_key = key_reg[127:0];
        else
            new_key = {n0, n1, n2, n3};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg    <= '0;
            keylen_reg <= 1'b0;
            gen_cnt    <= 4'd0;
            rcon       <= 8'h01;
            for (int i = 0; i < NKEYS; i++) mem[i] <= '0;
        end else if (start) begin
            key_reg    <= key;
            keylen_reg <= keylen;
            gen_cnt    <= 4'd0;
            rcon       <= 8'h01;
        end else if (gen_we) begin
            mem[gen_cnt] <= new_key;
            gen_cnt      <= gen_cnt + 4'd1;
            if (rcon_adv)
                rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end

    always_comb begin
        round_key = '0;
        for (int i = 0; i < NKEYS; i++)
            if (round == 4'(i) && round <= last_idx) round_key = mem[i];
    end

endmodule

// File: tb/tb_aes_key_mem.sv
// Directed bench for aes_key_mem using FIPS-197 key-expansion vectors.
module tb_aes_key_mem;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         init;
    logic         keylen;
    logic [255:0] key;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cycles;

    localparam logic [255:0] KEY128 =
        256'h2b7e151628aed2a6abf7158809cf4f3c_deadbeefcafef00d0123456789abcdef;
    localparam logic [255:0] KEY256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_mem dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .keylen    (keylen),
        .key       (key),
        .round     (round),
        .round_key (round_key),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    // Pulse init for one edge; returns #1 after the sampling edge with cycles=0.
    task automatic start(input logic kl, input logic [255:0] k);
        @(negedge clk);
        init   = 1'b1;
        keylen = kl;
        key    = k;
        @(posedge clk);
        #1;
        init   = 1'b0;
        key    = ~k;
        keylen = ~kl;
        cycles = 0;
    endtask

    task automatic wait_ready();
        while (!ready && cycles < 40) tick();
    endtask

    task automatic rk(input logic [3:0] r, input string tag, input logic [127:0] exp);
        round = r;
        #1;
        chk(tag, round_key, exp);
    endtask

    initial begin
        rst_n  = 1'b0;
        init   = 1'b0;
        keylen = 1'b0;
        key    = '0;
        round  = 4'd0;
        #12;
        chk("reset_ready", {127'd0, ready}, 128'd0);
        chk("reset_rk0", round_key, 128'd0);
        rst_n = 1'b1;

        // AES-128 from IDLE
        start(1'b0, KEY128);
        chk("gen_ready_low", {127'd0, ready}, 128'd0);
        wait_ready();
        chk("a128_latency", 128'(cycles), 128'd11);
        rk(4'd0,  "a128_rk0",  128'h2b7e151628aed2a6abf7158809cf4f3c);
        rk(4'd1,  "a128_rk1",  128'ha0fafe1788542cb123a339392a6c7605);
        rk(4'd2,  "a128_rk2",  128'hf2c295f27a96b9435935807a7359f67f);
        rk(4'd10, "a128_rk10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int r = 11; r <= 15; r++) rk(4'(r), "a128_oor", 128'd0);
        repeat (5) tick();
        chk("done_hold_ready", {127'd0, ready}, 128'd1);
        rk(4'd10, "done_hold_rk10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-256 restart from DONE
        start(1'b1, KEY256);
        chk("restart_ready_drop", {127'd0, ready}, 128'd0);
        wait_ready();
        chk("a256_latency", 128'(cycles), 128'd15);
        rk(4'd0,  "a256_rk0",  128'h603deb1015ca71be2b73aef0857d7781);
        rk(4'd1,  "a256_rk1",  128'h1f352c073b6108d72d9810a30914dff4);
        rk(4'd2,  "a256_rk2",  128'h9ba354118e6925afa51a8b5f2067fcde);
        rk(4'd14, "a256_rk14", 128'hfe4890d1e6188d0b046df344706c631e);
        rk(4'd15, "a256_oor",  128'd0);

        // init during GEN is ignored
        start(1'b0, KEY128);
        repeat (4) tick();
        init   = 1'b1;
        keylen = 1'b1;
        key    = KEY256;
        tick();
        init = 1'b0;
        wait_ready();
        chk("ign_latency", 128'(cycles), 128'd11);
        rk(4'd1,  "ign_rk1",  128'ha0fafe1788542cb123a339392a6c7605);
        rk(4'd10, "ign_rk10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rk(4'd11, "ign_oor",  128'd0);

        // asynchronous reset mid-GEN
        start(1'b1, KEY256);
        repeat (4) tick();
        round = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", {127'd0, ready}, 128'd0);
        chk("rst_rk0", round_key, 128'd0);
        #3;
        rst_n = 1'b1;
        repeat (20) tick();
        chk("post_rst_ready", {127'd0, ready}, 128'd0);
        rk(4'd1, "post_rst_rk1", 128'd0);
        start(1'b0, KEY128);
        wait_ready();
        chk("post_rst_latency", 128'(cycles), 128'd11);
        rk(4'd10, "post_rst_rk10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
